axi4_lite_master_ctrl: RTL
==========================

// Module: axi4_lite_master_ctrl
// PURPOSE
//  Parametrised AXI4-Lite master: converts a single-command request/response port into AXI4-Lite read or write.
//  Adds over the previous master: configurable widths, WSTRB byte enables, BRESP/RRESP reporting, watchdog timeout.
//  One outstanding transaction at a time; sits between a CPU/bus bridge and an AXI4-Lite peripheral interconnect.
// PARAMETERS
//  ADDR_W       32   AXI/command address width
//  DATA_W       32   data width (32 or 64); STRB_W = DATA_W/8 derived
//  TIMEOUT_CYC  256  cycles allowed per transaction before abort; 0 disables watchdog
// PORTS
//  ACLK         in   1        clock, all logic on rising edge
//  ARESETn      in   1        asynchronous active-low reset
//  AWADDR/AWVALID/AWREADY  out/out/in  ADDR_W/1/1  write address channel
//  WDATA/WSTRB/WVALID/WREADY  out/out/out/in  DATA_W/STRB_W/1/1  write data channel
//  BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
//  ARADDR/ARVALID/ARREADY  out/out/in  ADDR_W/1/1  read address channel
//  RDATA/RRESP/RVALID/RREADY  in/in/in/out  DATA_W/2/1/1  read data channel
//  cmd_valid    in   1        command request
//  cmd_ready    out  1        high only in IDLE; command accepted when cmd_valid&cmd_ready
//  cmd_write    in   1        1=write, 0=read
//  cmd_addr     in   ADDR_W   transaction address
//  cmd_wdata    in   DATA_W   write data
//  cmd_wstrb    in   STRB_W   write byte enables
//  rsp_valid    out  1        one-cycle completion pulse
//  rsp_write    out  1        completed transaction was a write
//  rsp_rdata    out  DATA_W   read data (0 for writes and timeouts)
//  rsp_resp     out  2        BRESP/RRESP, or 2'b10 on timeout
//  rsp_timeout  out  1        completion was a watchdog abort
// BEHAVIOUR
//  Reset: state=IDLE; all AXI VALID/READY=0; AWADDR/ARADDR/WDATA/WSTRB=0; cmd_ready=1; rsp_* all 0.
//  Command fields captured into registers on acceptance; AXI outputs driven only from registers.
//  FSM: IDLE -> WR_AW_W | RD_AR; WR_AW_W -> WR_B; WR_B -> RESP; RD_AR -> RD_R; RD_R -> RESP; RESP -> IDLE.
//  Accept in cycle N -> AWVALID & WVALID (write) or ARVALID (read) high from cycle N+1.
//  WR_AW_W: AWVALID and WVALID held independently until own handshake; aw_done/w_done flags set per
//   handshake; leave when both done (same-cycle handshakes included). VALID never drops before READY.
//  WR_B: BREADY=1; on BVALID capture BRESP -> RESP. RD_AR: ARVALID until ARREADY -> RD_R.
//  RD_R: RREADY=1; on RVALID capture RDATA/RRESP -> RESP.
//  RESP: rsp_valid=1 for exactly one cycle, cmd_ready=0; rsp_* hold until next completion.
//  Latency with zero-wait slave: accept N, handshake N+1, B/R handshake N+2, rsp_valid N+3, cmd_ready N+4.
//  Watchdog: counter cleared on accept, increments each cycle outside IDLE/RESP; reaching TIMEOUT_CYC
//   drops all VALID/READY that cycle, goes to RESP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
//   Handshake in same cycle as expiry wins (normal completion). Non-OKAY slave responses passed through.
//  cmd_valid outside IDLE ignored (no queueing). Async reset mid-transaction aborts immediately to reset values.
// TESTING
//  Write 0x4->0xDEADBEEF strb 0xF, AW/W/B ready immediately -> rsp_valid at N+3, rsp_resp=00, rsp_write=1.
//  Write with AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4, BREADY after both.
//  Read 0x8, slave RDATA=0x12345678 RRESP=10 after 2 waits -> rsp_rdata=0x12345678, rsp_resp=10, rsp_timeout=0.
//  Write strb 0x3 data 0xAABBCCDD -> WSTRB=0011, WDATA=0xAABBCCDD stable while WVALID & !WREADY.
//  TIMEOUT_CYC=16, ARREADY never -> ARVALID drops 16 cycles after accept, rsp_resp=10, rsp_timeout=1.
//  ARESETn low while WR_B with BVALID pending -> all outputs reset values, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi4_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns one command into an AXI4-Lite read or write
// and reports the result as a one-cycle response pulse, with a per-transaction watchdog.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | cmd_ready high, waiting for a command
// S_WR_AW_W | AWVALID / WVALID each held until their own handshake
// S_WR_B    | BREADY high, waiting for the write response
// S_RD_AR   | ARVALID held until ARREADY
// S_RD_R    | RREADY high, waiting for read data
// S_RESP    | rsp_valid pulse, then back to idle
module axi4_lite_master_ctrl #(
   parameter int  ADDR_W      = 32,
   parameter int  DATA_W      = 32,
   parameter int  TIMEOUT_CYC = 256,
   localparam int STRB_W      = DATA_W / 8
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   output logic [ADDR_W-1:0] AWADDR,
   output logic              AWVALID,
   input  logic              AWREADY,
   output logic [DATA_W-1:0] WDATA,
   output logic [STRB_W-1:0] WSTRB,
   output logic              WVALID,
   input  logic              WREADY,
   input  logic [1:0]        BRESP,
   input  logic              BVALID,
   output logic              BREADY,
   output logic [ADDR_W-1:0] ARADDR,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RVALID,
   output logic              RREADY,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [STRB_W-1:0] cmd_wstrb,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic              rsp_timeout
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_AW_W = 3'd1;
   localparam logic [2:0] S_WR_B    = 3'd2;
   localparam logic [2:0] S_RD_AR   = 3'd3;
   localparam logic [2:0] S_RD_R    = 3'd4;
   localparam logic [2:0] S_RESP    = 3'd5;

   localparam int              CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [STRB_W-1:0] r_wstrb;
   logic              r_write;
   logic              r_awvalid;
   logic              r_wvalid;
   logic              r_arvalid;
   logic              r_bready;
   logic              r_rready;
   logic              r_aw_done;
   logic              r_w_done;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_rsp_valid;
   logic              r_rsp_write;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic [1:0]        r_rsp_resp;
   logic              r_rsp_timeout;

   logic w_busy;
   logic w_expire;
   logic w_aw_hs;
   logic w_w_hs;
   logic w_aw_fin;
   logic w_w_fin;

   assign w_busy   = (r_state == S_WR_AW_W) || (r_state == S_WR_B) ||
                     (r_state == S_RD_AR)   || (r_state == S_RD_R);
   // The counter saturates at TO_LAST, so every busy cycle from the deadline on is an expiry cycle.
   assign w_expire = TO_EN && w_busy && (r_cnt == TO_LAST);
   assign w_aw_hs  = r_awvalid & AWREADY;
   assign w_w_hs   = r_wvalid & WREADY;
   assign w_aw_fin = r_aw_done | w_aw_hs;
   assign w_w_fin  = r_w_done | w_w_hs;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state       <= S_IDLE;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_wstrb       <= '0;
         r_write       <= 1'b0;
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_arvalid     <= 1'b0;
         r_bready      <= 1'b0;
         r_rready      <= 1'b0;
         r_aw_done     <= 1'b0;
         r_w_done      <= 1'b0;
         r_cnt         <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_write   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= 2'b00;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (TO_EN && w_busy && !w_expire) r_cnt <= r_cnt + CNT_W'(1);

         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_addr  <= cmd_addr;
                  r_wdata <= cmd_wdata;
                  r_wstrb <= cmd_wstrb;
                  r_write <= cmd_write;
                  r_cnt   <= '0;
                  if (cmd_write) begin
                     r_state   <= S_WR_AW_W;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                  end else begin
                     r_state   <= S_RD_AR;
                     r_arvalid <= 1'b1;
                  end
               end
            end

            S_WR_AW_W: begin
               if (w_aw_hs) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_fin && w_w_fin) begin
                  r_state  <= S_WR_B;
                  r_bready <= 1'b1;
               end else if (w_expire) begin
                  r_awvalid     <= 1'b0;
                  r_wvalid      <= 1'b0;
                  r_state       <= S_RESP;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_write   <= 1'b1;
                  r_rsp_rdata   <= '0;
                  r_rsp_resp    <= 2'b10;
                  r_rsp_timeout <= 1'b1;
               end
            end

            S_WR_B: begin
               if (BVALID || w_expire) begin
                  r_bready      <= 1'b0;
                  r_state       <= S_RESP;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_write   <= 1'b1;
                  r_rsp_rdata   <= '0;
                  r_rsp_resp    <= BVALID ? BRESP : 2'b10;
                  r_rsp_timeout <= !BVALID;
               end
            end

            S_RD_AR: begin
               if (ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RD_R;
               end else if (w_expire) begin
                  r_arvalid     <= 1'b0;
                  r_state       <= S_RESP;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_write   <= 1'b0;
                  r_rsp_rdata   <= '0;
                  r_rsp_resp    <= 2'b10;
                  r_rsp_timeout <= 1'b1;
               end
            end

            S_RD_R: begin
               if (RVALID || w_expire) begin
                  r_rready      <= 1'b0;
                  r_state       <= S_RESP;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_write   <= 1'b0;
                  r_rsp_rdata   <= RVALID ? RDATA : '0;
                  r_rsp_resp    <= RVALID ? RRESP : 2'b10;
                  r_rsp_timeout <= !RVALID;
               end
            end

            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready   = (r_state == S_IDLE);
   assign AWADDR      = r_addr;
   assign ARADDR      = r_addr;
   assign WDATA       = r_wdata;
   assign WSTRB       = r_wstrb;
   assign AWVALID     = r_awvalid;
   assign WVALID      = r_wvalid;
   assign ARVALID     = r_arvalid;
   assign BREADY      = r_bready;
   assign RREADY      = r_rready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_write   = r_rsp_write;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_resp    = r_rsp_resp;
   assign rsp_timeout = r_rsp_timeout;

endmodule
